// File: rtl/fault_recovery_sequencer.sv
// -----------------------------------------------------------------------------
// fault_recovery_sequencer
//
// Watches the system-state FSM and sequences recovery after a FAULT:
//   MONITOR -> COOLDOWN (shutdown held for COOLDOWN_CYCLES)
//           -> REQUEST  (recover_req to host, wait for recover_ack)
//           -> WAIT_CLEAR (wait for system_state == IDLE) -> MONITOR
// Repeated faults without a quiet period of QUIET_CYCLES non-FAULT cycles
// are counted in retry_cnt; a FAULT with the retry budget used up latches
// LOCKOUT until the operator clears it while the system is not faulted.
//
// Optional feature macro: FAULT_RECOVERY_ACK_TIMEOUT_EN
//   defined   : an unanswered request times out after ACK_TIMEOUT cycles and
//               counts as a failed attempt (retry or lockout).
//   undefined : REQUEST waits for recover_ack indefinitely; ACK_TIMEOUT unused.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   system_state  in   2  00 IDLE, 01 NORMAL, 10 WARNING, 11 FAULT
//   recover_ack   in   host acknowledge of recover_req (pulse or level)
//   lockout_clr   in   operator clear of lockout
//   shutdown      out  load/heater shutdown command
//   recover_req   out  recovery request to host
//   lockout       out  retry budget exhausted
//   retry_cnt     out  4  recovery attempts since last quiet period / clear
//   seq_state     out  3  0 MONITOR, 1 COOLDOWN, 2 REQUEST, 3 WAIT_CLEAR,
//                         4 LOCKOUT
// All outputs are registered.
// -----------------------------------------------------------------------------
module fault_recovery_sequencer #(
    parameter int COOLDOWN_CYCLES = 1000,
    parameter int MAX_RETRIES     = 3,
    parameter int ACK_TIMEOUT     = 16,
    parameter int QUIET_CYCLES    = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] system_state,
    input  logic       recover_ack,
    input  logic       lockout_clr,
    output logic       shutdown,
    output logic       recover_req,
    output logic       lockout,
    output logic [3:0] retry_cnt,
    output logic [2:0] seq_state
);

    // Elaboration-time parameter range checks.
    if (COOLDOWN_CYCLES < 1) begin : g_bad_cooldown
        $error("COOLDOWN_CYCLES must be >= 1");
    end
    if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_retries
        $error("MAX_RETRIES must be in 1..15");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT must be >= 1");
    end
    if (QUIET_CYCLES < 1) begin : g_bad_quiet
        $error("QUIET_CYCLES must be >= 1");
    end

    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    localparam logic [3:0]    MAX_R      = 4'(MAX_RETRIES);
    localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        ST_MONITOR    = 3'd0,
        ST_COOLDOWN   = 3'd1,
        ST_REQUEST    = 3'd2,
        ST_WAIT_CLEAR = 3'd3,
        ST_LOCKOUT    = 3'd4
    } state_t;

    state_t        state_q,       state_d;
    logic [3:0]    retry_cnt_q,   retry_cnt_d;
    logic [CW-1:0] cool_tmr_q,    cool_tmr_d;
    logic [QW-1:0] quiet_cnt_q,   quiet_cnt_d;
    logic          shutdown_q,    shutdown_d;
    logic          recover_req_q, recover_req_d;
    logic          lockout_q,     lockout_d;
`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
    logic [AW-1:0] ack_tmr_q,     ack_tmr_d;
`endif

    logic is_fault;
    logic is_idle;

    assign is_fault = (system_state == 2'b11);
    assign is_idle  = (system_state == 2'b00);

    // Retry counter never wraps: it stops at the budget.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= MAX_R) ? MAX_R : cnt + 4'd1;
    endfunction

    // -------------------------------------------------------------------------
    // State register (also holds counters and registered outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_MONITOR;
            retry_cnt_q   <= '0;
            cool_tmr_q    <= '0;
            quiet_cnt_q   <= '0;
            shutdown_q    <= 1'b0;
            recover_req_q <= 1'b0;
            lockout_q     <= 1'b0;
`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
            ack_tmr_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            retry_cnt_q   <= retry_cnt_d;
            cool_tmr_q    <= cool_tmr_d;
            quiet_cnt_q   <= quiet_cnt_d;
            shutdown_q    <= shutdown_d;
            recover_req_q <= recover_req_d;
            lockout_q     <= lockout_d;
`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
            ack_tmr_q     <= ack_tmr_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        cool_tmr_d  = cool_tmr_q;
        quiet_cnt_d = quiet_cnt_q;
`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
        ack_tmr_d   = ack_tmr_q;
`endif

        case (state_q)
            ST_MONITOR: begin
                if (is_fault) begin
                    quiet_cnt_d = '0;
                    if (retry_cnt_q == MAX_R) begin
                        state_d = ST_LOCKOUT;
                    end else begin
                        retry_cnt_d = sat_inc(retry_cnt_q);
                        cool_tmr_d  = COOL_LOAD;
                        state_d     = ST_COOLDOWN;
                    end
                end else if (quiet_cnt_q == QUIET_LAST) begin
                    // This cycle completes the quiet period: forget past retries.
                    quiet_cnt_d = '0;
                    retry_cnt_d = '0;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + QW'(1);
                end
            end

            ST_COOLDOWN: begin
                // Timer was loaded with N-1, so COOLDOWN lasts exactly N cycles.
                if (cool_tmr_q == '0) begin
                    state_d = ST_REQUEST;
`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
                    ack_tmr_d = ACK_LOAD;
`endif
                end else begin
                    cool_tmr_d = cool_tmr_q - CW'(1);
                end
            end

            ST_REQUEST: begin
                // Ack is checked first so it wins over a same-cycle timeout.
                if (recover_ack) begin
                    state_d = ST_WAIT_CLEAR;
                end
`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
                else if (ack_tmr_q == '0) begin
                    if (retry_cnt_q == MAX_R) begin
                        state_d = ST_LOCKOUT;
                    end else begin
                        retry_cnt_d = sat_inc(retry_cnt_q);
                        cool_tmr_d  = COOL_LOAD;
                        state_d     = ST_COOLDOWN;
                    end
                end else begin
                    ack_tmr_d = ack_tmr_q - AW'(1);
                end
`endif
            end

            ST_WAIT_CLEAR: begin
                if (is_idle) begin
                    state_d     = ST_MONITOR;
                    quiet_cnt_d = '0;
                end
            end

            ST_LOCKOUT: begin
                // A clear is only honoured once the fault itself has gone.
                if (lockout_clr && !is_fault) begin
                    retry_cnt_d = '0;
                    state_d     = ST_MONITOR;
                end
            end

            default: begin
                state_d = ST_MONITOR;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, registered alongside state_q
    // -------------------------------------------------------------------------
    always_comb begin
        shutdown_d    = (state_d != ST_MONITOR);
        recover_req_d = (state_d == ST_REQUEST);
        lockout_d     = (state_d == ST_LOCKOUT);
    end

    assign shutdown    = shutdown_q;
    assign recover_req = recover_req_q;
    assign lockout     = lockout_q;
    assign retry_cnt   = retry_cnt_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_fault_recovery_sequencer.sv
// Testbench for fault_recovery_sequencer: directed scenarios followed by a
// randomized phase; a reference model predicts the outputs after every clock
// edge into a queue, and a monitor on the falling edge compares the DUT.
module tb_fault_recovery_sequencer;

    localparam int C  = 8;
    localparam int MR = 2;
    localparam int AT = 4;
    localparam int QC = 16;

`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [1:0] system_state;
    logic       recover_ack;
    logic       lockout_clr;
    logic       shutdown;
    logic       recover_req;
    logic       lockout;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    fault_recovery_sequencer #(
        .COOLDOWN_CYCLES(C),
        .MAX_RETRIES    (MR),
        .ACK_TIMEOUT    (AT),
        .QUIET_CYCLES   (QC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .system_state(system_state),
        .recover_ack (recover_ack),
        .lockout_clr (lockout_clr),
        .shutdown    (shutdown),
        .recover_req (recover_req),
        .lockout     (lockout),
        .retry_cnt   (retry_cnt),
        .seq_state   (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sd;
        logic       rq;
        logic       lo;
        logic [3:0] rc;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase number plus elapsed-cycle counts.
    int m_st, m_retry, m_cool, m_ack, m_quiet;

    task automatic cmp(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_retry = 0; m_cool = 0; m_ack = 0; m_quiet = 0;
    endtask

    task automatic model_fail_attempt();
        if (m_retry == MR) m_st = 4;
        else begin
            m_retry++;
            m_cool = 0;
            m_st   = 1;
        end
    endtask

    task automatic model_step(input logic [1:0] ss, input logic ack, input logic clr);
        case (m_st)
            0: begin
                if (ss == 2'b11) begin
                    m_quiet = 0;
                    model_fail_attempt();
                end else begin
                    m_quiet++;
                    if (m_quiet == QC) begin
                        m_retry = 0;
                        m_quiet = 0;
                    end
                end
            end
            1: begin
                m_cool++;
                if (m_cool == C) begin
                    m_st  = 2;
                    m_ack = 0;
                end
            end
            2: begin
                if (ack) m_st = 3;
                else if (TMO_EN) begin
                    m_ack++;
                    if (m_ack == AT) model_fail_attempt();
                end
            end
            3: begin
                if (ss == 2'b00) begin
                    m_st    = 0;
                    m_quiet = 0;
                end
            end
            4: begin
                if (clr && ss != 2'b11) begin
                    m_retry = 0;
                    m_st    = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.sd = (m_st != 0);
        e.rq = (m_st == 2);
        e.lo = (m_st == 4);
        e.rc = 4'(m_retry);
        e.st = 3'(m_st);
        exp_q.push_back(e);
    endtask

    // Called at posedge+1: apply inputs, let one edge sample them, predict.
    task automatic step(input logic [1:0] ss, input logic ack, input logic clr);
        system_state = ss;
        recover_ack  = ack;
        lockout_clr  = clr;
        @(posedge clk);
        #1;
        model_step(ss, ack, clr);
        push_exp();
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_shutdown"}, int'(shutdown), 0);
        cmp({tag, "_req"}, int'(recover_req), 0);
        cmp({tag, "_lockout"}, int'(lockout), 0);
        cmp({tag, "_retry"}, int'(retry_cnt), 0);
        cmp({tag, "_state"}, int'(seq_state), 0);
    endtask

    // Called at posedge+1, before the falling edge consumes the last prediction.
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        push_exp();
        repeat (n) begin
            @(posedge clk);
            #1;
            push_exp();
        end
        reset_n = 1'b1;
    endtask

    // One complete fault/recover episode with ack on the first REQUEST cycle.
    task automatic episode();
        step(2'b11, 1'b0, 1'b0);
        repeat (C) step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
    endtask

    // Monitor: compare whenever a prediction is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("mon_shutdown", int'(shutdown), int'(e.sd));
                cmp("mon_req", int'(recover_req), int'(e.rq));
                cmp("mon_lockout", int'(lockout), int'(e.lo));
                cmp("mon_retry", int'(retry_cnt), int'(e.rc));
                cmp("mon_state", int'(seq_state), int'(e.st));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [1:0] rss;
        reset_n      = 1'b0;
        system_state = 2'b00;
        recover_ack  = 1'b0;
        lockout_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Single recovery: 8 cooldown cycles, ack 3 cycles after request.
        step(2'b11, 1'b0, 1'b0);
        cmp("s1_fault_state", int'(seq_state), 1);
        cmp("s1_fault_shutdown", int'(shutdown), 1);
        cmp("s1_fault_retry", int'(retry_cnt), 1);
        repeat (C - 1) step(2'b01, 1'b0, 1'b0);
        cmp("s1_cool_last_req", int'(recover_req), 0);
        step(2'b01, 1'b0, 1'b0);
        cmp("s1_req_rise", int'(recover_req), 1);
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        cmp("s1_req_held", int'(recover_req), 1);
        step(2'b01, 1'b1, 1'b0);
        cmp("s1_ack_req", int'(recover_req), 0);
        cmp("s1_ack_state", int'(seq_state), 3);
        step(2'b01, 1'b0, 1'b0);
        cmp("s1_wait_hold", int'(seq_state), 3);
        step(2'b00, 1'b0, 1'b0);
        cmp("s1_idle_state", int'(seq_state), 0);
        cmp("s1_idle_shutdown", int'(shutdown), 0);
        cmp("s1_idle_retry", int'(retry_cnt), 1);

        // Quiet reset: 15 quiet cycles keep the count, the 16th clears it.
        repeat (QC - 1) step(2'b00, 1'b0, 1'b0);
        cmp("quiet_15_retry", int'(retry_cnt), 1);
        step(2'b01, 1'b0, 1'b0);
        cmp("quiet_16_retry", int'(retry_cnt), 0);
        step(2'b11, 1'b0, 1'b0);
        cmp("quiet_next_fault_retry", int'(retry_cnt), 1);
        repeat (C) step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);

        // Reset mid-operation: in COOLDOWN, then in REQUEST.
        step(2'b11, 1'b0, 1'b0);
        repeat (3) step(2'b01, 1'b0, 1'b0);
        cmp("rst_pre_cool", int'(seq_state), 1);
        do_reset(2);
        step(2'b11, 1'b0, 1'b0);
        repeat (C) step(2'b01, 1'b0, 1'b0);
        cmp("rst_pre_req", int'(seq_state), 2);
        do_reset(1);
        step(2'b00, 1'b0, 1'b0);
        cmp("rst_after_state", int'(seq_state), 0);
        cmp("rst_after_retry", int'(retry_cnt), 0);

        // Lockout: three faults separated by only 5 quiet cycles.
        episode();
        repeat (5) step(2'b00, 1'b0, 1'b0);
        episode();
        repeat (5) step(2'b00, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        cmp("lock_state", int'(seq_state), 4);
        cmp("lock_flag", int'(lockout), 1);
        cmp("lock_retry", int'(retry_cnt), 2);
        step(2'b11, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b1);
        cmp("lock_clr_in_fault", int'(seq_state), 4);
        step(2'b00, 1'b0, 1'b1);
        cmp("lock_clr_state", int'(seq_state), 0);
        cmp("lock_clr_retry", int'(retry_cnt), 0);
        cmp("lock_clr_flag", int'(lockout), 0);
        step(2'b00, 1'b0, 1'b0);

`ifdef FAULT_RECOVERY_ACK_TIMEOUT_EN
        // Ack timeout: two unanswered requests end in lockout.
        step(2'b11, 1'b0, 1'b0);
        repeat (C) step(2'b01, 1'b0, 1'b0);
        repeat (AT - 1) step(2'b01, 1'b0, 1'b0);
        cmp("tmo_req_before", int'(recover_req), 1);
        step(2'b01, 1'b0, 1'b0);
        cmp("tmo_req_drop", int'(recover_req), 0);
        cmp("tmo_state", int'(seq_state), 1);
        cmp("tmo_retry", int'(retry_cnt), 2);
        repeat (C) step(2'b01, 1'b0, 1'b0);
        cmp("tmo_req2", int'(seq_state), 2);
        repeat (AT) step(2'b01, 1'b0, 1'b0);
        cmp("tmo_lock_state", int'(seq_state), 4);
        cmp("tmo_lock_flag", int'(lockout), 1);
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
`else
        // No timeout: request held indefinitely without ack.
        step(2'b11, 1'b0, 1'b0);
        repeat (C) step(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(2'b01, 1'b0, 1'b0);
            cmp("notmo_req", int'(recover_req), 1);
            cmp("notmo_state", int'(seq_state), 2);
        end
        step(2'b01, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
`endif

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(99));
            if (r < 6)       rss = 2'b11;
            else if (r < 50) rss = 2'b00;
            else if (r < 75) rss = 2'b01;
            else             rss = 2'b10;
            step(rss, ($urandom_range(99) < 30), ($urandom_range(99) < 20));
            if ($urandom_range(499) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        @(negedge clk);
        #1;
        cmp("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
